// File: rtl/cache_fill_pkg.sv
// cache_fill_pkg: shared state encoding and index-width helpers for the cache fill engine
package cache_fill_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} fill_state_t;
  localparam int WORD_BYTES = 2;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cache_fill_unit_rr_arbiter.sv
// rr_arbiter: round-robin grant whose priority rotates to the channel after each accepted grant
module rr_arbiter import cache_fill_pkg::*; #(
  parameter int NREQ = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic                   accept,
  output logic [NREQ-1:0]        gnt,
  output logic [idx_w(NREQ)-1:0] idx
);
  localparam int IW = idx_w(NREQ);
  logic [IW-1:0] ptr;
  logic found;
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        idx = IW'((int'(ptr) + k) % NREQ);
      end
    end
    gnt = found ? NREQ'(1) << idx : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (accept && found) ptr <= idx == IW'(NREQ - 1) ? '0 : idx + 1'b1;
  end
endmodule

// File: rtl/cache_fill_unit.sv
// cache_fill_unit: arbitrates cache block fills onto one pipelined memory and streams words back
module cache_fill_unit import cache_fill_pkg::*; #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8,
  parameter int NREQ   = 2,
  parameter bit CWF    = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          miss_req,
  input  logic [NREQ*ADDR_W-1:0]   miss_addr,
  output logic [NREQ-1:0]          busy,
  output logic [NREQ-1:0]          done,
  output logic                     mem_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     mem_data_valid,
  output logic                     fill_we,
  output logic [idx_w(WORDS)-1:0]  fill_word,
  output logic [DATA_W-1:0]        fill_data,
  output logic [idx_w(NREQ)-1:0]   fill_chan,
  output logic                     tag_we,
  output logic                     crit_valid
);
  localparam int OW = idx_w(WORDS);
  localparam int CW = OW + 1;
  localparam int BW = $clog2(WORD_BYTES);
  localparam int IW = idx_w(NREQ);
  fill_state_t state;
  logic [CW-1:0] issue_cnt, rcv_cnt;
  logic [OW-1:0] start, crit, issue_off, rcv_off;
  logic [ADDR_W-1:0] base, sel_addr;
  logic [NREQ-1:0] gnt, chan_oh;
  logic [IW-1:0] gnt_idx, chan;
  logic active, grant;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(miss_req),
    .accept(grant),
    .gnt(gnt),
    .idx(gnt_idx)
  );
  assign grant = state == IDLE && |miss_req;
  assign sel_addr = miss_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign active = state == ISSUE || state == WAIT;
  assign issue_off = start + issue_cnt[OW-1:0];
  assign rcv_off = start + rcv_cnt[OW-1:0];
  assign mem_en = state == ISSUE;
  assign mem_addr = mem_en ? base | ADDR_W'({issue_off, {BW{1'b0}}}) : '0;
  assign fill_we = active && mem_data_valid;
  assign fill_word = fill_we ? rcv_off : '0;
  assign fill_data = fill_we ? mem_data : '0;
  assign fill_chan = fill_we ? chan : '0;
  assign tag_we = fill_we && rcv_cnt == CW'(WORDS - 1);
  assign crit_valid = fill_we && rcv_off == crit;
  assign busy = active ? chan_oh : '0;
  assign done = state == DONE ? chan_oh : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      issue_cnt <= '0;
      rcv_cnt <= '0;
      base <= '0;
      start <= '0;
      crit <= '0;
      chan <= '0;
      chan_oh <= '0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          state <= ISSUE;
          issue_cnt <= '0;
          rcv_cnt <= '0;
          chan <= gnt_idx;
          chan_oh <= gnt;
          base <= sel_addr & ~ADDR_W'(WORDS * WORD_BYTES - 1);
          crit <= sel_addr[BW +: OW];
          start <= CWF ? sel_addr[BW +: OW] : '0;
        end
        ISSUE, WAIT: begin
          if (mem_en) issue_cnt <= issue_cnt + 1'b1;
          if (mem_en && issue_cnt == CW'(WORDS - 1)) state <= WAIT;
          if (fill_we) rcv_cnt <= rcv_cnt + 1'b1;
          if (tag_we) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_fill_unit.sv
// tb_cache_fill_unit: scoreboard bench for a word-0-first 2-channel unit and a critical-word-first 3-channel unit
module tb_cache_fill_unit;
  typedef logic [22:0] fill_t;
  logic clk = 1'b0;
  logic rst;
  logic [1:0][2:0] req;
  logic [1:0][47:0] maddr;
  logic [1:0] spur;
  wire [1:0] men, fwe, twe, cv, mdv;
  wire [1:0][2:0] busy, done, fwd;
  wire [1:0][15:0] madr, fdat, mdat;
  wire [1:0][1:0] fch;
  logic [7:0] vp [2] = '{8'h0, 8'h0};
  logic [15:0] ap [2][8];
  logic [15:0] qa [2][$];
  fill_t qf [2][$];
  logic [2:0] qd [2][$];
  int cyc = 0;
  int nvec = 0;
  int nbad = 0;
  int t0, t;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [15:0] md(int d, logic [15:0] a);
    return a ^ (d == 0 ? 16'hC3A5 : 16'h5A3C);
  endfunction
  cache_fill_unit #(.ADDR_W(16), .DATA_W(16), .WORDS(8), .NREQ(2), .CWF(1'b0)) dut_a (
    .clk(clk), .rst(rst), .miss_req(req[0][1:0]), .miss_addr(maddr[0][31:0]),
    .busy(busy[0][1:0]), .done(done[0][1:0]), .mem_en(men[0]), .mem_addr(madr[0]),
    .mem_data(mdat[0]), .mem_data_valid(mdv[0]), .fill_we(fwe[0]), .fill_word(fwd[0]),
    .fill_data(fdat[0]), .fill_chan(fch[0][0:0]), .tag_we(twe[0]), .crit_valid(cv[0])
  );
  assign busy[0][2] = 1'b0;
  assign done[0][2] = 1'b0;
  assign fch[0][1] = 1'b0;
  cache_fill_unit #(.ADDR_W(16), .DATA_W(16), .WORDS(8), .NREQ(3), .CWF(1'b1)) dut_b (
    .clk(clk), .rst(rst), .miss_req(req[1]), .miss_addr(maddr[1]),
    .busy(busy[1]), .done(done[1]), .mem_en(men[1]), .mem_addr(madr[1]),
    .mem_data(mdat[1]), .mem_data_valid(mdv[1]), .fill_we(fwe[1]), .fill_word(fwd[1]),
    .fill_data(fdat[1]), .fill_chan(fch[1]), .tag_we(twe[1]), .crit_valid(cv[1])
  );
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      vp[d] <= {vp[d][6:0], men[d]};
      ap[d][0] <= madr[d];
      for (int i = 1; i < 8; i++) ap[d][i] <= ap[d][i-1];
    end
  end
  assign mdv[0] = vp[0][3] | spur[0];
  assign mdv[1] = vp[1][5] | spur[1];
  assign mdat[0] = md(0, ap[0][3]);
  assign mdat[1] = md(1, ap[1][5]);
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (men[d]) begin
        if (qa[d].size() == 0) chk($sformatf("unexp_mem_en%0d", d), 64'(men[d]), 0);
        else chk($sformatf("mem_addr%0d", d), 64'(madr[d]), 64'(qa[d].pop_front()));
      end
      if (fwe[d]) begin
        if (qf[d].size() == 0) chk($sformatf("unexp_fill%0d", d), 64'(fwe[d]), 0);
        else chk($sformatf("fill%0d", d), {fwd[d], fdat[d], fch[d], twe[d], cv[d]}, 64'(qf[d].pop_front()));
      end else if (twe[d] || cv[d]) chk($sformatf("stray_tag_crit%0d", d), {twe[d], cv[d]}, 0);
      if (done[d] != 0) begin
        if (qd[d].size() == 0) chk($sformatf("unexp_done%0d", d), 64'(done[d]), 0);
        else chk($sformatf("done%0d", d), 64'(done[d]), 64'(qd[d].pop_front()));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic raise(int d, int ch, logic [15:0] a);
    maddr[d][ch*16 +: 16] = a;
    req[d][ch] = 1'b1;
  endtask
  task automatic expect_miss(int d, int ch, logic [15:0] a);
    logic [15:0] base, ad;
    logic [2:0] aw, w;
    base = a & 16'hFFF0;
    aw = a[3:1];
    for (int k = 0; k < 8; k++) begin
      w = d == 1 ? aw + 3'(k) : 3'(k);
      ad = base | {12'h0, w, 1'b0};
      qa[d].push_back(ad);
      qf[d].push_back({w, md(d, ad), 2'(ch), k == 7, w == aw});
    end
    qd[d].push_back(3'(1 << ch));
  endtask
  task automatic wait_done(int d, output int tdone);
    int n = 0;
    do begin
      tick();
      n++;
    end while (done[d] == 0 && n < 200);
    tdone = cyc;
    chk($sformatf("done_seen%0d", d), 64'(done[d] != 0), 1);
    req[d] = req[d] & ~done[d];
  endtask
  task automatic chk_quiet(int d, string nm);
    chk(nm, {busy[d], done[d], men[d], madr[d], fwe[d], fwd[d], fch[d], twe[d], cv[d]}, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    req = '0;
    maddr = '0;
    spur = '0;
    repeat (3) tick();
    chk_quiet(0, "reset_outs_a");
    chk_quiet(1, "reset_outs_b");
    rst = 1'b0;
    tick();
    t0 = cyc;
    raise(0, 0, 16'h1236);
    expect_miss(0, 0, 16'h1236);
    tick();
    chk("grant_latency_a", {men[0], busy[0]}, {1'b1, 3'b001});
    wait_done(0, t);
    chk("done_cycle_a", 64'(t - t0), 13);
    tick();
    spur[0] = 1'b1;
    #1;
    chk("spurious_idle_a", 64'(fwe[0]), 0);
    tick();
    spur[0] = 1'b0;
    raise(0, 1, 16'hFFF2);
    expect_miss(0, 1, 16'hFFF2);
    wait_done(0, t);
    tick();
    raise(0, 0, 16'h0100);
    raise(0, 1, 16'h2468);
    expect_miss(0, 0, 16'h0100);
    expect_miss(0, 1, 16'h2468);
    wait_done(0, t);
    wait_done(0, t);
    tick();
    raise(0, 0, 16'h0010);
    expect_miss(0, 0, 16'h0010);
    wait_done(0, t);
    tick();
    raise(0, 0, 16'h0ABC);
    raise(0, 1, 16'h7776);
    expect_miss(0, 1, 16'h7776);
    expect_miss(0, 0, 16'h0ABC);
    wait_done(0, t);
    wait_done(0, t);
    tick();
    t0 = cyc;
    raise(1, 1, 16'h123A);
    expect_miss(1, 1, 16'h123A);
    tick();
    chk("grant_latency_b", {men[1], busy[1]}, {1'b1, 3'b010});
    wait_done(1, t);
    chk("done_cycle_b", 64'(t - t0), 15);
    tick();
    raise(1, 0, 16'h0006);
    raise(1, 1, 16'h8888);
    raise(1, 2, 16'hFFF2);
    expect_miss(1, 2, 16'hFFF2);
    expect_miss(1, 0, 16'h0006);
    expect_miss(1, 1, 16'h8888);
    for (int i = 0; i < 3; i++) wait_done(1, t);
    tick();
    raise(1, 2, 16'h4442);
    expect_miss(1, 2, 16'h4442);
    repeat (9) tick();
    rst = 1'b1;
    req[1] = '0;
    tick();
    chk_quiet(1, "rst_abort_outs_b");
    chk("rst_pending_fills", 64'(qf[1].size()), 5);
    qa[1].delete();
    qf[1].delete();
    qd[1].delete();
    rst = 1'b0;
    repeat (12) tick();
    chk_quiet(1, "post_abort_idle_b");
    chk("leftover", 64'(qa[0].size() + qf[0].size() + qd[0].size() + qa[1].size() + qf[1].size() + qd[1].size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
